// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM state encoding,
// grant-source encoding and a small helper mapping a grant to its access state.
package mem_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE = 2'd0;
   localparam arb_state_t ST_IF   = 2'd1;
   localparam arb_state_t ST_DM   = 2'd2;
   localparam arb_state_t ST_RESP = 2'd3;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

   function automatic arb_state_t acc_state(input logic src);
      return (src == GNT_DM) ? ST_DM : ST_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (fetch/data) and memory-side signals of the arbiter.
// slave = arbiter view, master = pipeline + memory environment view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  if_req, if_addr, if_kill,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_kill,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-requester picker. ARB_RR_EN selects round-robin on
// last_grant; otherwise data always beats fetch.
module arb_pick
   import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
   input  logic last_grant,
`endif
   input  logic if_req,
   input  logic dm_req,
   output logic gnt_vld,
   output logic gnt_src
);

   assign gnt_vld = if_req | dm_req;

`ifdef ARB_RR_EN
   // On contention favour whichever port was not served last.
   always_comb begin
      gnt_src = GNT_IF;
      if (if_req && dm_req) gnt_src = ~last_grant;
      else if (dm_req)      gnt_src = GNT_DM;
   end
`else
   assign gnt_src = dm_req ? GNT_DM : GNT_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, ack-handshaked memory between the fetch and data
// ports. ARB_RR_EN switches arbitration from data-first to round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic         clock,
   input  logic         resetn,
   mem_arbiter_if.slave bus
);

   arb_state_t        state;
   logic              kill_pend;
   logic              kill_now;
   logic              gnt_vld;
   logic              gnt_src;

   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_ready_q;
   logic              dm_ready_q;

`ifdef ARB_RR_EN
   logic              last_grant;
`endif

   arb_pick u_pick (
`ifdef ARB_RR_EN
      .last_grant (last_grant),
`endif
      .if_req     (bus.if_req),
      .dm_req     (bus.dm_req),
      .gnt_vld    (gnt_vld),
      .gnt_src    (gnt_src)
   );

   // A kill arriving in the ack cycle still has to drop the result.
   assign kill_now = kill_pend | bus.if_kill;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         kill_pend   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
`ifdef ARB_RR_EN
         last_grant  <= GNT_IF;
`endif
      end else begin
         if_ready_q <= 1'b0;
         dm_ready_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  state    <= acc_state(gnt_src);
                  mem_en_q <= 1'b1;
`ifdef ARB_RR_EN
                  last_grant <= gnt_src;
`endif
                  if (gnt_src == GNT_DM) begin
                     mem_we_q    <= bus.dm_we;
                     mem_addr_q  <= bus.dm_addr;
                     mem_wdata_q <= bus.dm_wdata;
                  end else begin
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= bus.if_addr;
                     mem_wdata_q <= '0;
                  end
               end
            end
            ST_IF: begin
               kill_pend <= kill_now;
               if (bus.mem_ack) begin
                  state    <= ST_RESP;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (!kill_now) begin
                     if_rdata_q <= bus.mem_rdata;
                     if_ready_q <= 1'b1;
                  end
               end
            end
            ST_DM: begin
               if (bus.mem_ack) begin
                  state      <= ST_RESP;
                  mem_en_q   <= 1'b0;
                  mem_we_q   <= 1'b0;
                  dm_ready_q <= 1'b1;
                  if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
               end
            end
            ST_RESP: begin
               // Requester drops req on this edge, so nothing is sampled here.
               kill_pend <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.dm_ready  = dm_ready_q;

   a_ready_onehot: assert property (@(posedge clock) disable iff (!resetn)
      !(if_ready_q && dm_ready_q));
   a_we_needs_en: assert property (@(posedge clock) disable iff (!resetn)
      mem_we_q |-> mem_en_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: drives both pipeline ports and a memory
// with random ack latency, and checks against a transaction-level model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] m_if_rdata = '0;
   logic [31:0] m_dm_rdata = '0;
   logic        m_last     = GNT_IF;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.if_kill   = 1'b0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
   endtask

   // One memory access for a port: grant one cycle after the request is
   // visible in idle, d cycles of mem_en, ready in the following cycle.
   task automatic serve(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int d, input int koff);
      int   cnt = 0;
      logic killed;
      do begin
         @(negedge clock);
         cnt++;
      end while (!bus.mem_en && cnt < 6);
      chk("grant_lat", cnt, 1);
      chk("mem_addr", bus.mem_addr, addr);
      chk("mem_we", bus.mem_we, (port == GNT_DM) ? we : 1'b0);
      if (port == GNT_DM && we) chk("mem_wdata", bus.mem_wdata, wd);
      for (int i = 1; i <= d; i++) begin
         if (i > 1) @(negedge clock);
         bus.if_kill = (koff == i);
         if (i == d) begin
            chk("en_hold", bus.mem_en, 1);
            chk("addr_hold", bus.mem_addr, addr);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
         end else begin
            bus.mem_rdata = $urandom;
         end
      end
      @(negedge clock);
      bus.mem_ack   = 1'b0;
      bus.if_kill   = 1'b0;
      bus.mem_rdata = $urandom;
      killed = (port == GNT_IF) && (koff != 0);
      if (port == GNT_IF && !killed) m_if_rdata = rd;
      if (port == GNT_DM && !we)     m_dm_rdata = rd;
      chk("if_ready", bus.if_ready, (port == GNT_IF) && !killed);
      chk("dm_ready", bus.dm_ready, port == GNT_DM);
      chk("en_resp", bus.mem_en, 0);
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
      if (port == GNT_IF) bus.if_req = 1'b0;
      else                bus.dm_req = 1'b0;
      m_last = port;
      @(negedge clock);
      chk("ready_once", {bus.if_ready, bus.dm_ready}, 0);
      chk("we_idle", bus.mem_we, 0);
   endtask

   // Issue fetch and/or data requests together; the model orders the grants.
   task automatic txn(input bit want_if, input bit want_dm, input bit we,
                      input logic [31:0] if_a, input logic [31:0] dm_a, input logic [31:0] wd,
                      input logic [31:0] rd_if, input logic [31:0] rd_dm,
                      input int d, input int koff, input int stray_koff);
      logic first;
      bus.if_req   = want_if;
      bus.if_addr  = if_a;
      bus.dm_req   = want_dm;
      bus.dm_we    = we;
      bus.dm_addr  = dm_a;
      bus.dm_wdata = wd;
      if (want_if && want_dm) first = RR ? ~m_last : GNT_DM;
      else                    first = want_dm ? GNT_DM : GNT_IF;
      if (first == GNT_DM) serve(GNT_DM, we, dm_a, wd, rd_dm, d, stray_koff);
      else                 serve(GNT_IF, 1'b0, if_a, 32'h0, rd_if, d, koff);
      if (want_if && want_dm) begin
         if (first == GNT_DM) serve(GNT_IF, 1'b0, if_a, 32'h0, rd_if, d + 1, koff);
         else                 serve(GNT_DM, we, dm_a, wd, rd_dm, d + 1, stray_koff);
      end
   endtask

   initial begin
      clear_inputs();
      repeat (2) @(negedge clock);
      chk("rst_en", bus.mem_en, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_ready", {bus.if_ready, bus.dm_ready}, 0);
      chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      resetn = 1'b1;
      @(negedge clock);

      // fetch only, ack on the third mem_en cycle -> if_ready at cycle 4
      txn(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 32'h2008_0005, 32'h0, 3, 0, 0);
      // contention: load served first, fetch right after
      txn(1, 1, 0, 32'h0000_0044, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 32'hDEAD_BEEF, 2, 0, 0);
      // preload dm_rdata, then a store must leave it alone
      txn(0, 1, 0, 32'h0, 32'h0000_0108, 32'h0, 32'h0, 32'hAAAA_AAAA, 1, 0, 0);
      txn(0, 1, 1, 32'h0, 32'h0000_0104, 32'h1234_5678, 32'h0, 32'h5555_0000, 2, 0, 0);
      // kill mid-access, kill coincident with ack, then a clean fetch
      txn(1, 0, 0, 32'h0000_0080, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 4, 2, 0);
      txn(1, 0, 0, 32'h0000_0084, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 2, 2, 0);
      txn(1, 0, 0, 32'h0000_0088, 32'h0, 32'h0, 32'h0000_0013, 32'h0, 1, 0, 0);
      // kill seen only during a data access is ignored by the later fetch
      txn(1, 1, 0, 32'h0000_008C, 32'h0000_0200, 32'h0, 32'h0000_0033, 32'h0000_0077, 2, 0, 1);

      // reset in the middle of a data access
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b1;
      bus.dm_addr = 32'h0000_0300;
      bus.dm_wdata = 32'hCAFE_0001;
      repeat (2) @(negedge clock);
      chk("pre_rst_en", bus.mem_en, 1);
      resetn = 1'b0;
      #1;
      chk("arst_en", bus.mem_en, 0);
      chk("arst_we", bus.mem_we, 0);
      chk("arst_addr", bus.mem_addr, 0);
      chk("arst_wdata", bus.mem_wdata, 0);
      chk("arst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      chk("arst_ready", {bus.if_ready, bus.dm_ready}, 0);
      clear_inputs();
      m_if_rdata = '0;
      m_dm_rdata = '0;
      m_last     = GNT_IF;
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1357_9BDF;
      @(negedge clock);
      bus.mem_ack = 1'b0;
      chk("spur_ready", {bus.if_ready, bus.dm_ready}, 0);
      chk("spur_en", bus.mem_en, 0);
      @(negedge clock);
      chk("spur_ready2", {bus.if_ready, bus.dm_ready}, 0);
      chk("spur_rdata", {bus.if_rdata, bus.dm_rdata}, 0);

      // back-to-back contention to exercise the arbitration order
      for (int i = 0; i < 4; i++)
         txn(1, 1, 0, 32'h400 + 32'(i * 4), 32'h500 + 32'(i * 4), 32'h0,
             $urandom, $urandom, 1, 0, 0);

      for (int i = 0; i < 50; i++) begin
         bit want_if, want_dm;
         int d, koff;
         want_if = $urandom_range(0, 1);
         want_dm = $urandom_range(0, 1);
         if (!want_if && !want_dm) want_if = 1'b1;
         d    = $urandom_range(1, 4);
         koff = (want_if && $urandom_range(0, 2) == 0) ? $urandom_range(1, d) : 0;
         txn(want_if, want_dm, $urandom_range(0, 1), $urandom, $urandom, $urandom,
             $urandom, $urandom, d, koff, $urandom_range(0, 1));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
